// File: rtl/fft_io_pkg.sv
// fft_io_pkg: shared constants and types for the FFT host I/O controller.
// Frame geometry, data widths, FSM state encoding and bank helper.
package fft_io_pkg;

  localparam int N_PT   = 2048;
  localparam int BANK_W = 2;
  localparam int N_BANK = 4;
  localparam int IDX_W  = 11;
  localparam int SMP_W  = 16;
  localparam int RES_W  = 17;

  typedef enum logic [1:0] {
    LOAD,
    START,
    WAIT,
    UNLOAD
  } state_t;

  function automatic logic [N_BANK-1:0] bank_oh(
    input logic [BANK_W-1:0] b
  );
    bank_oh    = '0;
    bank_oh[b] = 1'b1;
  endfunction

endpackage

// File: rtl/fft_io_ctrl_if.sv
// fft_io_ctrl_if: sample input stream and result output stream.
// master = host/front-end side, slave = the controller.
interface fft_io_ctrl_if;
  import fft_io_pkg::*;

  logic [SMP_W-1:0] s_data;
  logic             s_valid;
  logic             s_ready;
  logic [RES_W-1:0] m_data;
  logic [IDX_W-1:0] m_bin;
  logic             m_valid;
  logic             m_last;
  logic             m_ready;

  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_bin, m_valid, m_last
  );

  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_bin, m_valid, m_last
  );

endinterface

// File: rtl/fft_io_fifo.sv
// fft_io_fifo: small show-ahead FIFO with occupancy count.
// Head entry is visible on rdata whenever empty is low.
module fft_io_fifo #(
  parameter int W = 28,
  parameter int D = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic                   empty,
  output logic [$clog2(D+1)-1:0] count
);

  localparam int CW = $clog2(D + 1);
  localparam int PW = (D > 1) ? $clog2(D) : 1;

  logic [W-1:0]  mem [D];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & ((count != CW'(D)) | do_pop);
  assign rdata   = mem[rp];

  // storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) mem[i] <= '0;
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= wdata;
        wp      <= (wp == PW'(D - 1)) ? '0 : wp + PW'(1);
      end
      if (do_pop) rp <= (rp == PW'(D - 1)) ? '0 : rp + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fft_io_ctrl.sv
// fft_io_ctrl: loads a 2048-sample frame into the FFT core banks,
// starts it, waits for completion and streams the results out.
module fft_io_ctrl
  import fft_io_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int RD_LAT = 1,
  parameter int FIFO_D = 4
) (
  input  logic              iCLK,
  input  logic              iRESET,
  fft_io_ctrl_if.slave      io,
  output logic              oBUSY,
  output logic              oFFT_START,
  output logic [SMP_W-1:0]  oFFT_DATA,
  output logic [ADDR_W-1:0] oFFT_ADDR_WR_0,
  output logic [ADDR_W-1:0] oFFT_ADDR_WR_1,
  output logic [ADDR_W-1:0] oFFT_ADDR_WR_2,
  output logic [ADDR_W-1:0] oFFT_ADDR_WR_3,
  output logic              oFFT_WE_0,
  output logic              oFFT_WE_1,
  output logic              oFFT_WE_2,
  output logic              oFFT_WE_3,
  output logic [ADDR_W-1:0] oFFT_ADDR_RD_0,
  output logic [ADDR_W-1:0] oFFT_ADDR_RD_1,
  output logic [ADDR_W-1:0] oFFT_ADDR_RD_2,
  output logic [ADDR_W-1:0] oFFT_ADDR_RD_3,
  input  logic [RES_W-1:0]  iFFT_DATA_RE_0,
  input  logic [RES_W-1:0]  iFFT_DATA_RE_1,
  input  logic [RES_W-1:0]  iFFT_DATA_RE_2,
  input  logic [RES_W-1:0]  iFFT_DATA_RE_3,
  input  logic              iFFT_RDY
);

  localparam int IW = ADDR_W + BANK_W;
  localparam int CW = $clog2(FIFO_D + 1);
  localparam int FW = RES_W + IW;

  state_t state, nstate;

  logic              s_ready_q;
  logic              accept;
  logic              last_in;
  logic [IW-1:0]     n;
  logic [N_BANK-1:0] we;
  logic [ADDR_W-1:0] waddr;

  logic              rdy_q, rdy_q2, rise;
  logic [IW:0]       k_iss;
  logic [ADDR_W-1:0] rd_addr;
  logic [RD_LAT:0]   pv;
  logic [BANK_W-1:0] pbank [RD_LAT+1];
  logic [IW-1:0]     pbin  [RD_LAT+1];
  logic [RES_W-1:0]  rdata;
  logic              issue;
  logic              credit_ok;
  int                used;

  logic [FW-1:0]     f_out;
  logic              f_empty;
  logic [CW-1:0]     f_count;
  logic              pop;
  logic              last_pop;

  assign accept   = io.s_valid & s_ready_q;
  assign last_in  = accept & (&n);
  assign rise     = rdy_q & ~rdy_q2;
  assign pop      = ~f_empty & io.m_ready;
  assign last_pop = pop & (&f_out[IW-1:0]);

  assign io.s_ready = s_ready_q;
  assign io.m_valid = ~f_empty;
  assign io.m_data  = f_out[FW-1:IW];
  assign io.m_bin   = f_out[IW-1:0];
  assign io.m_last  = ~f_empty & (&f_out[IW-1:0]);
  assign oBUSY      = (state != LOAD);

  assign oFFT_ADDR_WR_0 = waddr;
  assign oFFT_ADDR_WR_1 = waddr;
  assign oFFT_ADDR_WR_2 = waddr;
  assign oFFT_ADDR_WR_3 = waddr;
  assign oFFT_WE_0      = we[0];
  assign oFFT_WE_1      = we[1];
  assign oFFT_WE_2      = we[2];
  assign oFFT_WE_3      = we[3];
  assign oFFT_ADDR_RD_0 = rd_addr;
  assign oFFT_ADDR_RD_1 = rd_addr;
  assign oFFT_ADDR_RD_2 = rd_addr;
  assign oFFT_ADDR_RD_3 = rd_addr;

  // frame sequencing: LOAD -> START -> WAIT -> UNLOAD -> LOAD
  always_comb begin
    nstate = state;
    unique case (state)
      LOAD:    if (last_in) nstate = START;
      START:   nstate = WAIT;
      WAIT:    if (rise) nstate = UNLOAD;
      UNLOAD:  if (last_pop) nstate = LOAD;
      default: nstate = LOAD;
    endcase
  end

  // state, registered ready and one-shot start pulse
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state      <= LOAD;
      s_ready_q  <= 1'b0;
      oFFT_START <= 1'b0;
    end else begin
      state      <= nstate;
      s_ready_q  <= (nstate == LOAD);
      oFFT_START <= (state == START);
    end
  end

  // one write per accepted sample, bank chosen by the top index bits
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      n         <= '0;
      we        <= '0;
      waddr     <= '0;
      oFFT_DATA <= '0;
    end else if (accept) begin
      n         <= n + IW'(1);
      we        <= bank_oh(n[IW-1:ADDR_W]);
      waddr     <= n[ADDR_W-1:0];
      oFFT_DATA <= io.s_data;
    end else begin
      we        <= '0;
    end
  end

  // completion flag edge detect; a level high on entry is not an event
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      rdy_q  <= 1'b0;
      rdy_q2 <= 1'b0;
    end else begin
      rdy_q  <= iFFT_RDY;
      rdy_q2 <= rdy_q;
    end
  end

  // read credit: FIFO slots left after counting reads still in flight
  always_comb begin
    used = int'(f_count) - int'(pop);
    for (int i = 0; i <= RD_LAT; i++) used = used + int'(pv[i]);
    credit_ok = (used < FIFO_D);
    issue     = ~k_iss[IW] & credit_ok &
                (((state == WAIT) & rise) | (state == UNLOAD));
  end

  // read address issue and bank/index latency pipeline
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      k_iss   <= '0;
      rd_addr <= '0;
      pv      <= '0;
      for (int i = 0; i <= RD_LAT; i++) begin
        pbank[i] <= '0;
        pbin[i]  <= '0;
      end
    end else begin
      if (issue) begin
        k_iss   <= k_iss + (IW+1)'(1);
        rd_addr <= k_iss[ADDR_W-1:0];
      end else if (state == LOAD) begin
        k_iss   <= '0;
      end
      pv       <= {pv[RD_LAT-1:0], issue};
      pbank[0] <= k_iss[IW-1:ADDR_W];
      pbin[0]  <= k_iss[IW-1:0];
      for (int i = 1; i <= RD_LAT; i++) begin
        pbank[i] <= pbank[i-1];
        pbin[i]  <= pbin[i-1];
      end
    end
  end

  // pick the bank that owns the returning word
  always_comb begin
    rdata = iFFT_DATA_RE_0;
    unique case (pbank[RD_LAT])
      2'd0: rdata = iFFT_DATA_RE_0;
      2'd1: rdata = iFFT_DATA_RE_1;
      2'd2: rdata = iFFT_DATA_RE_2;
      2'd3: rdata = iFFT_DATA_RE_3;
    endcase
  end

  fft_io_fifo #(
    .W (FW),
    .D (FIFO_D)
  ) u_fifo (
    .clk   (iCLK),
    .rst_n (iRESET),
    .push  (pv[RD_LAT]),
    .wdata ({rdata, pbin[RD_LAT]}),
    .pop   (pop),
    .rdata (f_out),
    .empty (f_empty),
    .count (f_count)
  );

endmodule

// File: doc/fft_io_ctrl.md
# fft_io_ctrl

Host-side frame controller for the 2048-point radix-4 FFT core: drives its external load/unload interface. Accepts a real 16-bit sample stream, scatters 2048 samples into the core's four 512-word RAM banks, pulses the core's start, waits for completion, then reads the 17-bit real results back out as a backpressured stream. Sits between the acquisition front end and the spectrum post-processing chain, in the same clock domain as the FFT core.

## Interface
- ADDR_W, 9, per-bank address width (512 words/bank, 4 banks, N = 2048)
- RD_LAT, 1, core read latency in cycles, address-in to iFFT_DATA_RE_x valid (1..3)
- FIFO_D, 4, output FIFO depth (must be ≥ RD_LAT+1)
- One clock; reset is asynchronous and active-low.
- iCLK  in  1  clock
- iRESET  in  1  asynchronous active-low reset
- iS_DATA  in  16  input sample, two's complement
- iS_VALID  in  1  sample valid
- oS_READY  out  1  sample accepted when iS_VALID && oS_READY
- oM_DATA  out  17  result, real part, two's complement
- oM_BIN  out  11  linear index k of oM_DATA
- oM_VALID  out  1  result valid
- oM_LAST  out  1  high with k = 2047
- iM_READY  in  1  downstream accept
- oBUSY  out  1  high in every state except LOAD
- oFFT_START  out  1  one-cycle start pulse to core
- oFFT_DATA  out  16  write data, common to all banks
- oFFT_ADDR_WR_0..3  out  9 each  write address, all four equal
- oFFT_WE_0..3  out  1 each  one-hot bank write enable
- oFFT_ADDR_RD_0..3  out  9 each  read address, all four equal
- iFFT_DATA_RE_0..3  in  17 each  bank read data
- iFFT_RDY  in  1  core completion (level; rising edge is the event)

## Operation
- Mapping: linear index n (11 bit) → bank n[10:9], address n[8:0]. Same for load and unload.
- FSM states: LOAD → START → WAIT → UNLOAD → LOAD.
- LOAD: oS_READY = 1. Each accepted sample is registered into oFFT_DATA/ADDR_WR/WE (bank n[10:9] only) one cycle later; counter n increments. On accepting n = 2047, oS_READY drops the next cycle and FSM → START.
- START: waits one cycle so the final write commits, then oFFT_START = 1 for exactly one cycle, → WAIT.
- WAIT: iFFT_RDY registered; transition on 0→1 edge only. A level already high on entry is ignored until it falls and rises again.
- UNLOAD: read counter k issues addresses k[8:0] on all four read ports; bank select k[10:9] is pipelined RD_LAT cycles and picks iFFT_DATA_RE_x into an FIFO_D-entry show-ahead FIFO together with k. A read is issued only while (FIFO count + reads in flight) < FIFO_D; no overflow possible. After k = 2047 is popped (oM_VALID && iM_READY && oM_LAST), → LOAD.
- No arithmetic on data: input passed unmodified, output passed unmodified (17 bit).
- oFFT_WE_x are 0 outside LOAD's write cycle; read addresses hold last value outside UNLOAD.

## Timing
- Reset values: oS_READY 0 during reset, 1 on the first cycle after release (state LOAD, n = 0); oM_VALID 0, oM_LAST 0, oM_DATA 0, oM_BIN 0, oBUSY 0, oFFT_START 0, oFFT_WE_x 0, all addresses 0, oFFT_DATA 0; FIFO empty.
- Load latency: accept at cycle t → WE at t+1.
- Last sample accepted at t → oFFT_START at t+2, oBUSY high from t+1.
- iFFT_RDY rising edge seen at r (registered high at r) → first read address at r+1, FIFO write at r+1+RD_LAT, oM_VALID at r+2+RD_LAT.
- With iM_READY held high: one result per cycle sustained (FIFO_D ≥ RD_LAT+1).
- Final pop at cycle p → oBUSY 0 and oS_READY 1 at p+1.
- iS_VALID outside LOAD: ignored, no write. iM_READY while oM_VALID = 0: no effect.
- Reset mid-frame: all counters, FIFO, FSM cleared asynchronously; partial frame discarded; oFFT_START never issued for a partial frame.

## Structure
- Package fft_io_pkg: N_PT = 2048, bank/address widths, FSM state enum (LOAD, START, WAIT, UNLOAD), sample/result width constants.
- Sub-module fft_io_fifo: parameterized show-ahead FIFO (width 17+11, depth FIFO_D) with count output; top holds FSM, counters, write pipeline, read-latency pipeline and credit logic.

## Test plan
- Ramp load: samples n = 0..2047 value n, iS_VALID always → WE_x one-hot per n[10:9], address n[8:0], 2048 writes, single oFFT_START 2 cycles after last accept.
- Stale RDY: hold iFFT_RDY = 1 through START → no UNLOAD; drop then raise → first oM_VALID exactly RD_LAT+2 cycles after the edge.
- Unload with model core returning data = k on bank k[10:9], iM_READY = 1 → oM_BIN 0..2047 consecutive, oM_DATA = k, oM_LAST only at 2047, no gaps.
- Random iM_READY (50%) with RD_LAT = 3 → no loss/duplication, FIFO never exceeds 4, order preserved.
- Reset at n = 1000 during LOAD → outputs at reset values; next full frame of 2048 produces exactly one oFFT_START.
- Back-to-back frames: oS_READY high the cycle after final pop; second frame data lands at n = 0..2047.
